// File: rtl/fpm_pkg.sv
// Shared widths and types for the floating-point multiplier final-add slice.
package fpm_pkg;

    localparam int FPM_PROD_W  = 48;
    localparam int FPM_SPLIT_W = 24;

    typedef logic [47:0] prod_t;

endpackage

// File: rtl/fpm_cpa.sv
// Parameterised ripple carry-propagate adder with carry-in and carry-out.
module fpm_cpa #(
    parameter int N = 24
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/fpm_final_add.sv
// Two-stage split carry-propagate adder closing the Dadda tree of the multiplier.
// Optional rounding guard/sticky extraction is enabled by FPM_FINAL_ADD_STICKY_EN.
module fpm_final_add
    import fpm_pkg::*;
#(
    parameter int W     = FPM_PROD_W,
    parameter int SPLIT = FPM_SPLIT_W
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] row_s,
    input  logic [W-1:0] row_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] prod,
    output logic         norm,
    output logic         guard,
    output logic         sticky
);

    localparam int HW = W - SPLIT;

    // Handshake: a word moves when valid && ready on the same rising edge.
    // A stage loads when it is empty or its contents leave this cycle; in_ready
    // is derived only from out_ready and the stage valid flags, never in_valid.
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;
    logic in_xfer;
    logic s1_xfer;

    logic [SPLIT-1:0] s1_lo;
    logic             s1_c_lo;
    logic [HW-1:0]    s1_s_hi;
    logic [HW-1:0]    s1_c_hi;
    logic [W-1:0]     s2_prod;

    logic [SPLIT-1:0] lo_sum;
    logic             lo_carry;
    logic [HW-1:0]    hi_sum;
    logic             hi_carry_unused;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign in_xfer  = in_valid && s1_load;
    assign s1_xfer  = s1_valid && s2_load;

    fpm_cpa #(.N(SPLIT)) u_cpa_lo (
        .a    (row_s[SPLIT-1:0]),
        .b    (row_c[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_carry)
    );

    fpm_cpa #(.N(HW)) u_cpa_hi (
        .a    (s1_s_hi),
        .b    (s1_c_hi),
        .cin  (s1_c_lo),
        .sum  (hi_sum),
        .cout (hi_carry_unused)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c_lo  <= 1'b0;
            s1_s_hi  <= '0;
            s1_c_hi  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
            end
            if (in_xfer) begin
                s1_lo   <= lo_sum;
                s1_c_lo <= lo_carry;
                s1_s_hi <= row_s[W-1:SPLIT];
                s1_c_hi <= row_c[W-1:SPLIT];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
            if (s1_xfer) begin
                s2_prod <= {hi_sum, s1_lo};
            end
        end
    end

    assign out_valid = s2_valid;
    assign prod      = s2_prod;
    assign norm      = s2_prod[W-1];

`ifdef FPM_FINAL_ADD_STICKY_EN
    logic s1_sl;
    logic s1_b22;
    logic s2_guard;
    logic s2_sticky;
    logic hi_msb;

    assign hi_msb = hi_sum[HW-1];

    // The rounding point sits one bit lower when the product is not normalised.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_sl     <= 1'b0;
            s1_b22    <= 1'b0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_sl  <= |lo_sum[SPLIT-3:0];
                s1_b22 <= lo_sum[SPLIT-2];
            end
            if (s1_xfer) begin
                s2_guard  <= hi_msb ? s1_lo[SPLIT-1] : s1_b22;
                s2_sticky <= hi_msb ? (s1_sl | s1_b22) : s1_sl;
            end
        end
    end

    assign guard  = s2_guard;
    assign sticky = s2_sticky;
`else
    assign guard  = 1'b0;
    assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fpm_final_add.sv
// Randomised bench for fpm_final_add: scoreboard of exact sums plus directed corner cases.
// Build with FPM_FINAL_ADD_STICKY_EN to check the guard/sticky outputs.
module tb_fpm_final_add;
    import fpm_pkg::*;

    logic  clk;
    logic  n_rst;
    logic  in_valid;
    logic  in_ready;
    prod_t row_s;
    prod_t row_c;
    logic  out_valid;
    logic  out_ready;
    prod_t prod;
    logic  norm;
    logic  guard;
    logic  sticky;

    int n_vec = 0;
    int n_err = 0;

    // {guard, sticky, prod}
    logic [49:0] exp_q[$];

    fpm_final_add dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_s     (row_s),
        .row_c     (row_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .norm      (norm),
        .guard     (guard),
        .sticky    (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: exact sum, rounding point at bit 23 (normalised) or bit 22.
    function automatic logic [49:0] model(input prod_t s, input prod_t c);
        prod_t p;
        logic  g;
        logic  st;
        p  = s + c;
        g  = 1'b0;
        st = 1'b0;
`ifdef FPM_FINAL_ADD_STICKY_EN
        if (p[47]) begin
            g  = p[23];
            st = (p[22:0] != 23'd0);
        end else begin
            g  = p[22];
            st = (p[21:0] != 22'd0);
        end
`endif
        return {g, st, p};
    endfunction

    function automatic prod_t rand_row();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: r[23:0] = 24'hFF_FFFF;
            1: r = 64'hFFFF_FFFF_FFFF_FFFF;
            2: r = 64'(r[7:0]);
            default: ;
        endcase
        return r[47:0];
    endfunction

    // One clock: drive at the falling edge, then score the handshakes that the
    // next rising edge will complete.
    task automatic cycle(input logic v, input prod_t s, input prod_t c, input logic ordy);
        logic [49:0] e;
        @(negedge clk);
        in_valid  = v;
        row_s     = s;
        row_c     = c;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("prod", 64'(prod), 64'(e[47:0]));
                check("norm", 64'(norm), 64'(e[47]));
                check("guard", 64'(guard), 64'(e[49]));
                check("sticky", 64'(sticky), 64'(e[48]));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(s, c));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, '0, 1'b1);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic single(input prod_t s, input prod_t c);
        cycle(1'b1, s, c, 1'b1);
        check("single_accept", 64'(in_ready), 64'd1);
        cycle(1'b0, '0, '0, 1'b1);
        check("lat_edge1", 64'(out_valid), 64'd0);
        cycle(1'b0, '0, '0, 1'b1);
        check("lat_edge2", 64'(out_valid), 64'd1);
        drain();
    endtask

    prod_t held;

    initial begin
        n_rst     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        row_s     = '0;
        row_c     = '0;
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_prod", 64'(prod), 64'd0);
        check("rst_norm", 64'(norm), 64'd0);
        check("rst_guard", 64'(guard), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed corners: low-half carry into bit 24, rounding bits, overflow.
        single(48'h0000_00FF_FFFF, 48'h0000_0000_0001);
        single(48'h8000_0000_0000, 48'h0000_0000_0003);
        single(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
        single(48'h0000_0080_0000, 48'h0000_0040_0000);

        // Back-to-back stream at full rate.
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, rand_row(), rand_row(), 1'b1);
            if (i >= 2) begin
                check("tput_valid", 64'(out_valid), 64'd1);
            end
            check("tput_ready", 64'(in_ready), 64'd1);
        end
        drain();

        // Stall with input pressure: two accepts then back-pressure.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, rand_row(), rand_row(), 1'b0);
            check("stall_in_ready", 64'(in_ready), (i < 2) ? 64'd1 : 64'd0);
            if (i == 2) begin
                held = prod;
            end
            if (i >= 2) begin
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_prod_stable", 64'(prod), 64'(held));
            end
        end
        // Release while full with new input: retire one and accept one.
        cycle(1'b1, rand_row(), rand_row(), 1'b1);
        check("release_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Random valid/ready traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_row(), rand_row(),
                  1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Reset with two results in flight.
        cycle(1'b1, rand_row(), rand_row(), 1'b0);
        cycle(1'b1, rand_row(), rand_row(), 1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        n_rst    = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_prod", 64'(prod), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("midrst_release_ready", 64'(in_ready), 64'd1);
        cycle(1'b0, '0, '0, 1'b1);
        check("midrst_no_output", 64'(out_valid), 64'd0);
        single(48'h1234_5678_9ABC, 48'h0FED_CBA9_8765);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
